arm_data_mem: RTL

- Parametrised data memory for the ARM core, the next generation of the fixed single-cycle `memory` block.
- Adds four capabilities:
  - configurable data width and depth;
  - byte-lane write enables for STRB/STR;
  - a req/ready/resp handshake with programmable wait states, so multicycle and pipelined cores can stall on it;
  - error reporting for out-of-range or misaligned accesses.
- Sits between the core's load/store path and the simulation/top-level harness.

---
 rtl/arm_mem_pkg.sv | 32 +++
 rtl/arm_mem_array.sv | 36 +++
 rtl/arm_data_mem.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_pkg
//  Purpose  : Shared types, constants and width helpers for the ARM data memory
//  Revision : 1.0  initial release
// ============================================================================
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width of a field that must exist even when clog2 collapses to zero.
    function automatic int clog2_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int OFFSET_BITS        = clog2(BYTES_PER_WORD);

endpackage
`default_nettype wire

// File: rtl/arm_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : arm_mem_array
//  Purpose  : Byte-lane writable word array, synchronous write, combinational read
//  Revision : 1.0  initial release
// ============================================================================
module arm_mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Storage is deliberately not reset; contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/arm_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : arm_data_mem
//  Purpose  : Parametrised data memory with req/ready/resp handshake, wait
//             states, byte-lane writes and range/alignment error reporting
//  Revision : 1.0  initial release
// ============================================================================
module arm_data_mem
    import arm_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 256,
    parameter int                    WAIT_STATES = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    ready,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err
);

    localparam int c_bytes_per_word = DATA_WIDTH / 8;
    localparam int c_offset_bits    = clog2(c_bytes_per_word);
    localparam int c_idx_w          = clog2_min1(DEPTH_WORDS);
    localparam int c_cnt_w          = clog2_min1(WAIT_STATES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_load   = c_cnt_w'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] c_lane_mask  = ADDR_WIDTH'(c_bytes_per_word - 1);
    localparam logic [ADDR_WIDTH-1:0] c_depth      = ADDR_WIDTH'(DEPTH_WORDS);

    mem_state_t r_state, w_next;

    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_we;
    logic [DATA_WIDTH/8-1:0] r_be;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_ready;
    logic                    w_resp;
    logic                    w_enter_resp;
    logic                    w_we_sel;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_err;
    logic [c_idx_w-1:0]      w_idx;
    logic [DATA_WIDTH-1:0]   w_array_rdata;
    logic                    w_array_we;

    // With zero wait states RESP is entered on the accept edge, so decode
    // must look at the live inputs while idle and the held copy otherwise.
    assign w_addr   = (r_state == IDLE) ? addr : r_addr;
    assign w_we_sel = (r_state == IDLE) ? we   : r_we;
    assign w_offset = w_addr - BASE_ADDR;
    assign w_word   = w_offset >> c_offset_bits;
    assign w_err    = ((w_offset & c_lane_mask) != '0) ||
                      (w_addr < BASE_ADDR) ||
                      (w_word >= c_depth);
    assign w_idx    = w_word[c_idx_w-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (req) begin
                    w_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_resp = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && req) begin
                r_we    <= we;
                r_be    <= be;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_cnt   <= c_cnt_load;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we_sel) ? '0 : w_array_rdata;
            end
        end
    end

    assign w_array_we = (r_state == RESP) && r_we && !r_err;

    arm_mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_array (
        .clk     (clk),
        .i_we    (w_array_we),
        .i_be    (r_be),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_array_rdata)
    );

    assign ready      = w_ready;
    assign resp_valid = w_resp;
    assign rdata      = r_rdata;
    assign err        = r_err;

endmodule
`default_nettype wire
